// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, FSM encoding and request payload for the regfile writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned WORD        = 32;
    localparam int unsigned RF_ADDR_W   = 5;
    localparam int unsigned RF_NUM_REGS = 32;

    typedef enum logic {
        WBA_INIT = 1'b0,
        WBA_RUN  = 1'b1
    } wba_state_e;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] dest;
        logic [WORD-1:0]      data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin arbiter: first valid requester at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]          valid,
    input  logic [$clog2(NREQ)-1:0]  ptr,
    output logic [NREQ-1:0]          grant_c,
    output logic [$clog2(NREQ)-1:0]  grant_idx_c,
    output logic                     any_c
);
    localparam int unsigned IDW = $clog2(NREQ);

    int unsigned idx;

    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        any_c       = 1'b0;
        idx         = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!any_c && valid[idx]) begin
                any_c       = 1'b1;
                grant_c[idx] = 1'b1;
                grant_idx_c = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port among NREQ writeback requesters, clearing the regfile after reset.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned NUM_REGS   = RF_NUM_REGS,
    parameter int unsigned INIT_CLEAR = 1,
    parameter int unsigned ZERO_R0    = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*RF_ADDR_W-1:0]   req_dest,
    input  logic [NREQ*WORD-1:0]        req_data,
    output logic                        rf_write,
    output logic [RF_ADDR_W-1:0]        rf_address_dest,
    output logic [WORD-1:0]             rf_write_data,
    output logic [$clog2(NREQ)-1:0]     grant_id,
    output logic                        init_done
);
    localparam int unsigned IDW = $clog2(NREQ);

    wba_state_e           state, state_nxt;
    logic [RF_ADDR_W-1:0] cnt, cnt_nxt;
    logic [IDW-1:0]       ptr, ptr_nxt;
    logic                 rf_write_nxt, init_done_nxt;
    logic [RF_ADDR_W-1:0] addr_nxt;
    logic [WORD-1:0]      data_nxt;
    logic [IDW-1:0]       gid_nxt;

    logic [NREQ-1:0] grant_c;
    logic [IDW-1:0]  win_c;
    logic            any_c;
    wb_req_t         sel_c;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .valid       (req_valid),
        .ptr         (ptr),
        .grant_c     (grant_c),
        .grant_idx_c (win_c),
        .any_c       (any_c)
    );

    // Payload of the current winner
    always_comb begin
        sel_c.dest = req_dest[RF_ADDR_W*32'(win_c) +: RF_ADDR_W];
        sel_c.data = req_data[WORD*32'(win_c) +: WORD];
    end

    // Grants are only offered once the clear sequence is over
    always_comb begin
        req_ready = (state == WBA_RUN) ? grant_c : '0;
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        ptr_nxt       = ptr;
        rf_write_nxt  = 1'b0;
        addr_nxt      = rf_address_dest;
        data_nxt      = rf_write_data;
        gid_nxt       = grant_id;
        init_done_nxt = init_done;
        case (state)
            WBA_INIT: begin
                rf_write_nxt = 1'b1;
                addr_nxt     = cnt;
                data_nxt     = '0;
                cnt_nxt      = cnt + RF_ADDR_W'(1);
                if (cnt == RF_ADDR_W'(NUM_REGS - 1)) begin
                    state_nxt     = WBA_RUN;
                    cnt_nxt       = '0;
                    init_done_nxt = 1'b1;
                end
            end
            WBA_RUN: begin
                init_done_nxt = 1'b1;
                if (any_c) begin
                    // Writes to r0 are consumed but never reach the regfile
                    rf_write_nxt = !((ZERO_R0 != 0) && (sel_c.dest == '0));
                    addr_nxt     = sel_c.dest;
                    data_nxt     = sel_c.data;
                    gid_nxt      = win_c;
                    ptr_nxt      = (32'(win_c) == NREQ - 1) ? '0 : IDW'(32'(win_c) + 1);
                end
            end
            default: state_nxt = WBA_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= (INIT_CLEAR != 0) ? WBA_INIT : WBA_RUN;
            cnt             <= '0;
            ptr             <= '0;
            rf_write        <= 1'b0;
            rf_address_dest <= '0;
            rf_write_data   <= '0;
            grant_id        <= '0;
            init_done       <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            ptr             <= ptr_nxt;
            rf_write        <= rf_write_nxt;
            rf_address_dest <= addr_nxt;
            rf_write_data   <= data_nxt;
            grant_id        <= gid_nxt;
            init_done       <= init_done_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a behavioural regfile on its write port.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_dest;
    logic [63:0] req_data;
    logic        rf_write;
    logic [4:0]  rf_address_dest;
    logic [31:0] rf_write_data;
    logic [0:0]  grant_id;
    logic        init_done;

    logic [31:0] rf [32];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NREQ(2), .NUM_REGS(32), .INIT_CLEAR(1), .ZERO_R0(1)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_dest        (req_dest),
        .req_data        (req_data),
        .rf_write        (rf_write),
        .rf_address_dest (rf_address_dest),
        .rf_write_data   (rf_write_data),
        .grant_id        (grant_id),
        .init_done       (init_done)
    );

    always @(posedge clk) begin
        if (rf_write) rf[rf_address_dest] <= rf_write_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] d, input logic [31:0] v);
        req_dest[5*i +: 5]   = d;
        req_data[32*i +: 32] = v;
    endtask

    task automatic chk_out(input string tag, input logic w, input logic [4:0] a,
                           input logic [31:0] d, input logic [0:0] g);
        chk({tag, "_write"}, 32'(rf_write), 32'(w));
        if (w) begin
            chk({tag, "_addr"}, 32'(rf_address_dest), 32'(a));
            chk({tag, "_data"}, rf_write_data, d);
            chk({tag, "_gid"},  32'(grant_id), 32'(g));
        end
    endtask

    // Clear sequence: 32 writes of zero to 0..31, ready held low while requests are pending
    task automatic run_clear();
        req_valid = 2'b11;
        chk("init_ready0", 32'(req_ready), 32'd0);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("init_write", 32'(rf_write), 32'd1);
            chk("init_addr", 32'(rf_address_dest), 32'(i));
            chk("init_data", rf_write_data, 32'd0);
            chk("init_done", 32'(init_done), (i == 31) ? 32'd1 : 32'd0);
            if (i < 31) chk("init_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 2'b00;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'hDEAD_0000 + 32'(i);
        reset_n   = 1'b0;
        req_valid = 2'b11;
        req_dest  = '0;
        req_data  = '0;
        repeat (2) @(negedge clk);
        chk("rst_write", 32'(rf_write), 32'd0);
        chk("rst_addr", 32'(rf_address_dest), 32'd0);
        chk("rst_data", rf_write_data, 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_done", 32'(init_done), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);

        // 1: clear sequence
        reset_n = 1'b1;
        run_clear();
        @(negedge clk);
        chk("idle_write", 32'(rf_write), 32'd0);
        chk("clr_r31", rf[31], 32'd0);
        chk("clr_r5", rf[5], 32'd0);

        // 2: single requester
        set_req(0, 5'd2, 32'd10);
        req_valid = 2'b01;
        #1 chk("t2_ready", 32'(req_ready), 32'b01);
        @(negedge clk);
        req_valid = 2'b00;
        chk_out("t2", 1'b1, 5'd2, 32'd10, 1'b0);
        @(negedge clk);
        chk("t2_rf2", rf[2], 32'd10);
        chk("t2_idle", 32'(rf_write), 32'd0);
        chk("t2_hold_addr", 32'(rf_address_dest), 32'd2);

        // bring pointer back to 0 through a requester-1 transfer
        set_req(1, 5'd20, 32'd77);
        req_valid = 2'b10;
        #1 chk("p_ready", 32'(req_ready), 32'b10);
        @(negedge clk);
        req_valid = 2'b00;
        chk_out("p", 1'b1, 5'd20, 32'd77, 1'b1);

        // 3: both continuously valid, alternating grants without bubbles
        set_req(0, 5'd3, 32'd25);
        set_req(1, 5'd9, 32'd7);
        req_valid = 2'b11;
        for (int j = 0; j < 5; j++) begin
            #1 chk("t3_ready", 32'(req_ready), (j % 2 == 0) ? 32'b01 : 32'b10);
            @(negedge clk);
            if (j % 2 == 0) chk_out("t3_r0", 1'b1, 5'd3, 32'd25, 1'b0);
            else            chk_out("t3_r1", 1'b1, 5'd9, 32'd7, 1'b1);
        end

        // 4: same dest, pointer now 1: req1 first, req0 last
        set_req(0, 5'd12, 32'd5);
        set_req(1, 5'd12, 32'd6);
        #1 chk("t4_ready_a", 32'(req_ready), 32'b10);
        @(negedge clk);
        chk_out("t4_a", 1'b1, 5'd12, 32'd6, 1'b1);
        chk("t4_ready_b", 32'(req_ready), 32'b01);
        @(negedge clk);
        req_valid = 2'b00;
        chk_out("t4_b", 1'b1, 5'd12, 32'd5, 1'b0);
        @(negedge clk);
        chk("t4_rf12", rf[12], 32'd5);

        // 5: r0 write consumed; set pointer to 0 first so the advance is visible
        set_req(1, 5'd13, 32'd1);
        req_valid = 2'b10;
        @(negedge clk);
        set_req(0, 5'd0, 32'd99);
        req_valid = 2'b01;
        #1 chk("t5_ready", 32'(req_ready), 32'b01);
        @(negedge clk);
        chk("t5_nowrite", 32'(rf_write), 32'd0);
        set_req(0, 5'd4, 32'd44);
        set_req(1, 5'd6, 32'd66);
        req_valid = 2'b11;
        #1 chk("t5_ptr_adv", 32'(req_ready), 32'b10);
        @(negedge clk);
        req_valid = 2'b00;
        chk_out("t5_next", 1'b1, 5'd6, 32'd66, 1'b1);
        chk("t5_r0", rf[0], 32'd0);

        // 6: reset during the clear sequence, then a full restart
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_mid_addr", 32'(rf_address_dest), 32'd9);
        reset_n = 1'b0;
        #1;
        chk("t6_async_write", 32'(rf_write), 32'd0);
        chk("t6_async_addr", 32'(rf_address_dest), 32'd0);
        chk("t6_async_done", 32'(init_done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_clear();
        @(negedge clk);
        chk("t6_rf2", rf[2], 32'd0);
        chk("t6_rf12", rf[12], 32'd0);
        chk("t6_rf31", rf[31], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
